tdm_demultiplexer_4ch: RTL

- Receive-side counterpart of the 4:1 multiplexer used as a time-division transmitter. The transmitter sends lane w[s] on y while s steps 0,1,2,3.
- This block takes the serialized slot stream plus a frame-sync marker and rebuilds the 4-lane word w.
- Each completed word is presented with a one-cycle valid pulse.
- Sits at the receive end of the lab's TDM link, feeding downstream 4-lane logic; flags framing errors and counts good frames.

---
 rtl/tdm_demultiplexer_4ch_if.sv | 25 ++
 rtl/tdm_demultiplexer_4ch.sv | 88 ++++++++
 2 files changed

// File: rtl/tdm_demultiplexer_4ch_if.sv
// Slot-stream / word bus between the TDM receive link and the demultiplexer.
// master drives the serial slots, slave returns the rebuilt word and status.
interface tdm_demultiplexer_4ch_if #(
  parameter int SLOT_W = 1,
  parameter int CNT_W  = 8
);
  logic [SLOT_W-1:0]   y;
  logic                y_valid;
  logic                frame_sync;
  logic [4*SLOT_W-1:0] w;
  logic                w_valid;
  logic [1:0]          s;
  logic                sync_err;
  logic [CNT_W-1:0]    frame_cnt;

  modport master (
    output y, y_valid, frame_sync,
    input  w, w_valid, s, sync_err, frame_cnt
  );

  modport slave (
    input  y, y_valid, frame_sync,
    output w, w_valid, s, sync_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demultiplexer_4ch.sv
// Rebuilds a 4-lane word from a frame-synced TDM slot stream; flags early
// sync markers and counts completed frames.
module tdm_demultiplexer_4ch #(
  parameter int SLOT_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tdm_demultiplexer_4ch_if.slave bus
);
  typedef enum logic {HUNT, COLLECT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          s_q, s_d;
  logic [3*SLOT_W-1:0] stage_q, stage_d;
  logic [4*SLOT_W-1:0] w_q, w_d;
  logic                w_valid_q, w_valid_d;
  logic                sync_err_q, sync_err_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    stage_d     = stage_q;
    w_d         = w_q;
    w_valid_d   = 1'b0;
    sync_err_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (bus.y_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            stage_d[0 +: SLOT_W] = bus.y;
            s_d                  = 2'd1;
            state_d              = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.frame_sync && s_q != 2'd0) begin
            // Early marker: drop the partial frame and restart on this beat.
            sync_err_d           = 1'b1;
            stage_d[0 +: SLOT_W] = bus.y;
            s_d                  = 2'd1;
          end else if (s_q == 2'd3) begin
            w_d         = {bus.y, stage_q};
            w_valid_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
            s_d         = 2'd0;
            state_d     = HUNT;
          end else begin
            for (int k = 0; k < 3; k++) begin
              if (s_q == 2'(k)) stage_d[k*SLOT_W +: SLOT_W] = bus.y;
            end
            s_d = s_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      s_q         <= '0;
      stage_q     <= '0;
      w_q         <= '0;
      w_valid_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      stage_q     <= stage_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.w         = w_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.s         = s_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule
